lsu_ctrl: RTL and testbench
===========================

# lsu_ctrl

- Load/store controller that sits directly upstream of the 16x4 data memory.
- Accepts load and store requests from the execute stage over a valid/ready handshake.
- Sequences the memory's one-cycle-pulse enables and its synchronous-read latency.
- Returns load data to writeback over a second valid/ready handshake, with at most one request in flight.

## Interface
Parameters:
- AW, 4, address width; matches the data memory address port.
- DW, 4, data width; matches the data memory data ports.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  AW  word address.
- req_wdata  in  DW  store data; ignored for loads.
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer takes the response.
- resp_data  out  DW  load data.
- busy  out  1  high whenever state is not IDLE.
- mem_write_enable  out  1  to data memory write enable.
- mem_read_enable  out  1  to data memory read enable.
- mem_addr  out  AW  to data memory address.
- mem_write_data  out  DW  to data memory write data.
- mem_read_data  in  DW  from data memory registered read data.

## Operation
- FSM states: IDLE, ISSUE, RD_WAIT, RESP.
- req_ready = (state == IDLE); busy = !req_ready.
- **Accept:** req_valid && req_ready latches req_we, req_addr and req_wdata, then moves to ISSUE.
- **ISSUE:**
  - Asserts exactly one of mem_write_enable or mem_read_enable for exactly one cycle.
  - mem_addr and mem_write_data are driven from the latched values.
  - Store: next state IDLE (or RESP, see Configuration).
  - Load: next state RD_WAIT.
- **RD_WAIT:** mem_read_data is valid in this cycle. It is captured into resp_data at the edge ending the cycle, then state moves to RESP.
- **RESP:** resp_valid = 1 and resp_data is held stable until resp_valid && resp_ready, then state moves to IDLE.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Outside ISSUE, both mem enables are 0. mem_addr and mem_write_data hold their last values.
- Request fields are ignored when req_ready = 0.
- No reordering or hazards: a load following a store always reads the stored value, because the store's write completes before the load's read is issued.

## Timing
- Reset (rst_n = 0, asynchronous): state = IDLE, req_ready = 1 after the first edge with rst_n high. All other outputs are 0: resp_valid, resp_data, busy, mem_write_enable, mem_read_enable, mem_addr, mem_write_data.
- Load accepted in cycle N:
  - mem_read_enable high in N+1.
  - Data captured at the end of N+2.
  - resp_valid high from N+3.
  - With resp_ready held high, IDLE and req_ready = 1 return in N+4.
- Store accepted in cycle N:
  - mem_write_enable high in N+1; the memory is written at the end of N+1.
  - req_ready = 1 again in N+2.
  - Maximum store throughput is 1 per 2 cycles.
- Backpressure: resp_ready low keeps the controller in RESP indefinitely with resp_data unchanged. No new request is accepted.
- Reset mid-operation:
  - Any in-flight request is dropped and the pending response is discarded.
  - Enables deassert immediately (asynchronous clear).
  - A store in ISSUE is not performed if rst_n falls before the edge ending ISSUE.
- Address wrap: none. Addresses 0..15 map directly, and address 15 is an ordinary location.

## Configuration
- LSU_STORE_ACK_EN defined:
  - Stores go ISSUE -> RESP with resp_valid = 1 and resp_data = the stored data.
  - req_ready returns after the response handshake, giving the consumer one completion per request.
- Not defined:
  - Stores produce no response; ISSUE -> IDLE.
  - resp_valid is asserted only for loads.

## Test plan
- **Reset:** assert rst_n = 0 mid-load (in RD_WAIT) -> all outputs 0 immediately. After release: req_ready = 1, resp_valid = 0, and no response ever arrives for the dropped load.
- **Store then load:**
  - Store addr 0x5, data 0xA, followed immediately by a load from addr 0x5.
  - mem_write_enable pulses one cycle with addr 5 and data A.
  - The load's resp_data = 0xA, with resp_valid 3 cycles after accept.
- **Backpressure:** load addr 0x3 (preloaded 0x7) with resp_ready low for 5 cycles -> resp_valid and resp_data = 0x7 stay stable, req_ready stays 0. Release -> one handshake, then IDLE.
- **Boundary address:** store 0xF to addr 0xF, then load addr 0xF -> 0xF; addr 0x0 is unaffected and reads 0x0.
- **Request ignored while busy:** hold req_valid high with changing fields while busy -> only the first request is issued, and exactly one enable pulse occurs per accept.
- **LSU_STORE_ACK_EN on:** store 0x9 to addr 0x2 -> resp_valid with resp_data = 0x9, and req_ready returns only after resp_ready. Macro off: no resp_valid for the same store.

Source files
------------

// File: rtl/lsu_ctrl_if.sv
// rtl/lsu_ctrl_if.sv - request/response handshake bundle between execute, lsu_ctrl and writeback
//
// Request channel (execute -> lsu_ctrl):
//   req_valid, req_ready, req_we (1 = store), req_addr [AW], req_wdata [DW]
// Response channel (lsu_ctrl -> writeback):
//   resp_valid, resp_ready, resp_data [DW]
// Modports: master = execute/writeback side, slave = lsu_ctrl side.

interface lsu_ctrl_if #(
    parameter int AW = 4,
    parameter int DW = 4
);
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          resp_valid;
    logic          resp_ready;
    logic [DW-1:0] resp_data;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_data
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_data
    );
endinterface

// File: rtl/lsu_ctrl.sv
// rtl/lsu_ctrl.sv - load/store sequencer in front of the 16x4 synchronous-read data memory
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   bus (slave)         request/response handshakes, see lsu_ctrl_if
//   busy                high whenever the FSM is not IDLE
//   mem_write_enable    one-cycle write pulse to the data memory
//   mem_read_enable     one-cycle read pulse to the data memory
//   mem_addr            memory address (holds its last value between requests)
//   mem_write_data      memory write data (holds its last value between stores)
//   mem_read_data       registered read data, valid the cycle after mem_read_enable
//
// Optional feature macro: LSU_STORE_ACK_EN
//   defined   - stores also return a response carrying the stored data
//   undefined - stores complete silently, only loads respond
//
// At most one request is in flight, so a load always observes every earlier store.
// Every output is a flop; nothing combinational reaches an output from an input.

module lsu_ctrl #(
    parameter int AW = 4,
    parameter int DW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    lsu_ctrl_if.slave     bus,
    output logic          busy,
    output logic          mem_write_enable,
    output logic          mem_read_enable,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_write_data,
    input  logic [DW-1:0] mem_read_data
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        RD_WAIT = 2'd2,
        RESP    = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic          we_q, we_d;
    logic          req_ready_q, req_ready_d;
    logic          busy_q, busy_d;
    logic          resp_valid_q, resp_valid_d;
    logic [DW-1:0] resp_data_q, resp_data_d;
    logic          mem_we_q, mem_we_d;
    logic          mem_re_q, mem_re_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;

    always_comb begin
        state_d      = state_q;
        we_d         = we_q;
        resp_valid_d = resp_valid_q;
        resp_data_d  = resp_data_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        // Enables are pulses: they are only raised on the transition into ISSUE.
        mem_we_d     = 1'b0;
        mem_re_d     = 1'b0;

        case (state_q)
            IDLE: begin
                // req_ready_q is 0 only in the first cycle after reset, when
                // the controller must not yet accept anything.
                if (bus.req_valid && req_ready_q) begin
                    we_d       = bus.req_we;
                    mem_addr_d = bus.req_addr;
                    if (bus.req_we) begin
                        mem_wdata_d = bus.req_wdata;
                    end
                    mem_we_d = bus.req_we;
                    mem_re_d = !bus.req_we;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                if (we_q) begin
`ifdef LSU_STORE_ACK_EN
                    resp_valid_d = 1'b1;
                    resp_data_d  = mem_wdata_q;
                    state_d      = RESP;
`else
                    state_d      = IDLE;
`endif
                end else begin
                    state_d = RD_WAIT;
                end
            end
            RD_WAIT: begin
                // Memory output registered on the ISSUE edge is valid now.
                resp_valid_d = 1'b1;
                resp_data_d  = mem_read_data;
                state_d      = RESP;
            end
            RESP: begin
                if (bus.resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        req_ready_d = (state_d == IDLE);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            we_q         <= 1'b0;
            req_ready_q  <= 1'b0;
            busy_q       <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            mem_we_q     <= 1'b0;
            mem_re_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            we_q         <= we_d;
            req_ready_q  <= req_ready_d;
            busy_q       <= busy_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            mem_we_q     <= mem_we_d;
            mem_re_q     <= mem_re_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    assign bus.req_ready    = req_ready_q;
    assign bus.resp_valid   = resp_valid_q;
    assign bus.resp_data    = resp_data_q;
    assign busy             = busy_q;
    assign mem_write_enable = mem_we_q;
    assign mem_read_enable  = mem_re_q;
    assign mem_addr         = mem_addr_q;
    assign mem_write_data   = mem_wdata_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb/tb_lsu_ctrl.sv - directed self-checking bench for lsu_ctrl with a 16x4 synchronous-read memory model

module tb_lsu_ctrl;
    localparam int AW = 4;
    localparam int DW = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lsu_ctrl_if #(.AW(AW), .DW(DW)) bus ();

    logic          busy;
    logic          mem_we;
    logic          mem_re;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;

    lsu_ctrl #(.AW(AW), .DW(DW)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .bus              (bus.slave),
        .busy             (busy),
        .mem_write_enable (mem_we),
        .mem_read_enable  (mem_re),
        .mem_addr         (mem_addr),
        .mem_write_data   (mem_wdata),
        .mem_read_data    (mem_rdata)
    );

    // 16x4 data memory: synchronous write, registered read; address 3 preloaded with 7.
    logic [DW-1:0] mem [16] = '{3: 4'h7, default: 4'h0};
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= mem[mem_addr];
    end

    int wr_pulses = 0;
    int rd_pulses = 0;
    int resp_cycles = 0;
    always @(posedge clk) begin
        if (mem_we) wr_pulses = wr_pulses + 1;
        if (mem_re) rd_pulses = rd_pulses + 1;
        if (bus.resp_valid) resp_cycles = resp_cycles + 1;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_store(input logic [3:0] a, input logic [3:0] d);
        int w0 = wr_pulses;
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_addr  = a;
        bus.req_wdata = d;
        step();
        check("st_we", mem_we, 1);
        check("st_re", mem_re, 0);
        check("st_addr", mem_addr, a);
        check("st_wdata", mem_wdata, d);
        check("st_busy", busy, 1);
        bus.req_valid = 1'b0;
        step();
`ifdef LSU_STORE_ACK_EN
        check("st_ack_valid", bus.resp_valid, 1);
        check("st_ack_data", bus.resp_data, d);
        check("st_ack_ready", bus.req_ready, 0);
        step();
`endif
        check("st_ready", bus.req_ready, 1);
        check("st_we_off", mem_we, 0);
        check("st_rv_off", bus.resp_valid, 0);
        check("st_pulses", wr_pulses - w0, 1);
    endtask

    task automatic do_load(input logic [3:0] a, input logic [3:0] exp);
        int r0 = rd_pulses;
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = a;
        step();
        check("ld_re", mem_re, 1);
        check("ld_we", mem_we, 0);
        check("ld_addr", mem_addr, a);
        check("ld_ready_busy", bus.req_ready, 0);
        bus.req_valid = 1'b0;
        step();
        check("ld_rv_early", bus.resp_valid, 0);
        check("ld_re_off", mem_re, 0);
        step();
        check("ld_rv", bus.resp_valid, 1);
        check("ld_data", bus.resp_data, exp);
        step();
        check("ld_ready", bus.req_ready, 1);
        check("ld_rv_off", bus.resp_valid, 0);
        check("ld_pulses", rd_pulses - r0, 1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rv"}, bus.resp_valid, 0);
        check({tag, "_rdata"}, bus.resp_data, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_we"}, mem_we, 0);
        check({tag, "_re"}, mem_re, 0);
        check({tag, "_addr"}, mem_addr, 0);
        check({tag, "_wdata"}, mem_wdata, 0);
    endtask

    initial begin
        int w0;
        int r0;
        int rc0;
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        bus.resp_ready = 1'b1;

        // Reset state
        step();
        check_all_zero("rst");
        rst_n = 1'b1;
        step();
        check("rst_ready", bus.req_ready, 1);
        check("rst_busy", busy, 0);

        // Store then load
        do_store(4'h5, 4'hA);
        do_load(4'h5, 4'hA);

        // Backpressure: load addr 3 (preloaded 7), resp_ready low for 5 cycles
        bus.resp_ready = 1'b0;
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b0;
        bus.req_addr   = 4'h3;
        step();
        w0 = wr_pulses;
        bus.req_we    = 1'b1;
        bus.req_addr  = 4'h9;
        bus.req_wdata = 4'h4;
        step();
        step();
        for (int i = 0; i < 5; i++) begin
            check("bp_rv", bus.resp_valid, 1);
            check("bp_data", bus.resp_data, 4'h7);
            check("bp_ready", bus.req_ready, 0);
            step();
        end
        bus.req_valid  = 1'b0;
        bus.resp_ready = 1'b1;
        step();
        check("bp_ready_back", bus.req_ready, 1);
        check("bp_rv_off", bus.resp_valid, 0);
        check("bp_no_store", wr_pulses - w0, 0);
        check("bp_mem9", mem[9], 0);

        // Request fields changing while busy
        r0 = rd_pulses;
        w0 = wr_pulses;
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = 4'h3;
        step();
        check("hold_re", mem_re, 1);
        bus.req_we    = 1'b1;
        bus.req_addr  = 4'h6;
        bus.req_wdata = 4'h5;
        step();
        bus.req_we   = 1'b0;
        bus.req_addr = 4'h7;
        step();
        check("hold_data", bus.resp_data, 4'h7);
        bus.req_valid = 1'b0;
        step();
        check("hold_rd_pulses", rd_pulses - r0, 1);
        check("hold_wr_pulses", wr_pulses - w0, 0);
        check("hold_addr", mem_addr, 4'h3);
        check("hold_mem6", mem[6], 0);

        // Reset during RD_WAIT
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = 4'h5;
        step();
        bus.req_valid = 1'b0;
        step();
        rc0 = resp_cycles;
        #1 rst_n = 1'b0;
        #1;
        check_all_zero("rstld");
        check("rstld_ready", bus.req_ready, 0);
        step();
        rst_n = 1'b1;
        step();
        check("rstld_ready_back", bus.req_ready, 1);
        check("rstld_rv", bus.resp_valid, 0);
        repeat (6) step();
        check("rstld_no_resp", resp_cycles - rc0, 0);

        // Reset during a store's ISSUE cycle: write must not happen
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_addr  = 4'h1;
        bus.req_wdata = 4'h6;
        step();
        check("rstst_we", mem_we, 1);
        bus.req_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("rstst_we_clr", mem_we, 0);
        step();
        rst_n = 1'b1;
        step();
        check("rstst_mem1", mem[1], 0);
        do_load(4'h1, 4'h0);

        // Boundary address
        do_store(4'hF, 4'hF);
        do_load(4'hF, 4'hF);
        do_load(4'h0, 4'h0);

        // Store acknowledge behaviour
`ifdef LSU_STORE_ACK_EN
        bus.resp_ready = 1'b0;
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b1;
        bus.req_addr   = 4'h2;
        bus.req_wdata  = 4'h9;
        step();
        bus.req_valid = 1'b0;
        step();
        for (int i = 0; i < 2; i++) begin
            check("ack_rv", bus.resp_valid, 1);
            check("ack_data", bus.resp_data, 4'h9);
            check("ack_ready", bus.req_ready, 0);
            step();
        end
        bus.resp_ready = 1'b1;
        step();
        check("ack_ready_back", bus.req_ready, 1);
        check("ack_rv_off", bus.resp_valid, 0);
`else
        rc0 = resp_cycles;
        do_store(4'h2, 4'h9);
        repeat (3) step();
        check("noack_resp", resp_cycles - rc0, 0);
`endif
        do_load(4'h2, 4'h9);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
